// File: rtl/core_pkg.sv
// Shared types and default addresses for the multi-cycle core sequencer.
package core_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_EXEC,
    S_MEM,
    S_WB,
    S_HALT
  } state_t;

  localparam int DEF_RESET_PC = 0;
  localparam int DEF_DONE_PC  = 58;

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones; clear has priority over enable.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         en_i,
  input  logic         clr_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] q_q, q_d;

  always_comb begin
    q_d = q_q;
    if (clr_i)                  q_d = '0;
    else if (en_i && q_q != '1) q_d = q_q + W'(1);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) q_q <= '0;
    else         q_q <= q_d;
  end

  assign q_o = q_q;

endmodule

// File: rtl/core_seq.sv
// Multi-cycle FETCH/EXEC/MEM/WB sequencer: owns the PC, gates RF/DM enables,
// stalls on the DMem handshake with a timeout, and keeps saturating perf counters.
module core_seq
  import core_pkg::*;
#(
  parameter int PC_W     = 12,
  parameter int RESET_PC = DEF_RESET_PC,
  parameter int DONE_PC  = DEF_DONE_PC,
  parameter int CNT_W    = 16,
  parameter int MEM_TO   = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_i,
  input  logic             jen_i,
  input  logic [PC_W-1:0]  jump_i,
  input  logic             is_ld_i,
  input  logic             is_st_i,
  input  logic             halt_op_i,
  input  logic             mem_ack_i,
  output logic [PC_W-1:0]  pc_o,
  output logic             ir_en_o,
  output logic             rf_wen_en_o,
  output logic             dm_req_o,
  output logic             dm_we_o,
  output logic             busy_o,
  output logic             done_o,
  output logic             err_o,
  output logic [CNT_W-1:0] cycle_cnt_o,
  output logic [CNT_W-1:0] instr_cnt_o
);

  localparam int              WT_W    = $clog2(MEM_TO + 1);
  localparam logic [WT_W-1:0] WT_LAST = WT_W'(MEM_TO - 1);
  localparam logic [PC_W-1:0] PC_RST  = PC_W'(RESET_PC);
  localparam logic [PC_W-1:0] PC_DONE = PC_W'(DONE_PC);

  state_t          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d, jump_q, jump_d;
  logic            jen_q, jen_d, st_q, st_d, err_q, err_d;
  logic [WT_W-1:0] wait_cnt;
  logic            launch, busy, in_mem, in_wb;

  assign launch = (state_q == S_IDLE || state_q == S_HALT) && start_i;
  assign busy   = state_q inside {S_FETCH, S_EXEC, S_MEM, S_WB};
  assign in_mem = (state_q == S_MEM);
  assign in_wb  = (state_q == S_WB);

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    jen_d   = jen_q;
    jump_d  = jump_q;
    st_d    = st_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE, S_HALT: begin
        if (start_i) begin
          state_d = S_FETCH;
          pc_d    = PC_RST;
          err_d   = 1'b0;
        end
      end
      S_FETCH: state_d = S_EXEC;
      S_EXEC: begin
        // ld+st together resolves to a store since only is_st is kept
        jen_d  = jen_i;
        jump_d = jump_i;
        st_d   = is_st_i;
        if (halt_op_i || pc_q == PC_DONE) state_d = S_HALT;
        else if (is_ld_i || is_st_i)      state_d = S_MEM;
        else                              state_d = S_WB;
      end
      S_MEM: begin
        // an ack arriving on the timeout cycle still completes the access
        if (mem_ack_i) state_d = S_WB;
        else if (wait_cnt == WT_LAST) begin
          state_d = S_HALT;
          err_d   = 1'b1;
        end
      end
      S_WB: begin
        state_d = S_FETCH;
        pc_d    = jen_q ? jump_q : pc_q + PC_W'(1);
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
      pc_q    <= PC_RST;
      jen_q   <= 1'b0;
      jump_q  <= '0;
      st_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      jen_q   <= jen_d;
      jump_q  <= jump_d;
      st_q    <= st_d;
      err_q   <= err_d;
    end
  end

  sat_counter #(.W(CNT_W)) u_cycle_cnt (
    .clk_i(clk_i), .rst_ni(rst_ni), .en_i(busy), .clr_i(launch), .q_o(cycle_cnt_o)
  );

  sat_counter #(.W(CNT_W)) u_instr_cnt (
    .clk_i(clk_i), .rst_ni(rst_ni), .en_i(in_wb), .clr_i(launch), .q_o(instr_cnt_o)
  );

  // holds the number of MEM cycles already elapsed; zero on MEM entry
  sat_counter #(.W(WT_W)) u_wait_cnt (
    .clk_i(clk_i), .rst_ni(rst_ni), .en_i(in_mem), .clr_i(!in_mem), .q_o(wait_cnt)
  );

  assign pc_o        = pc_q;
  assign ir_en_o     = (state_q == S_FETCH);
  assign rf_wen_en_o = in_wb && !st_q;
  assign dm_req_o    = in_mem;
  assign dm_we_o     = in_mem && st_q;
  assign busy_o      = busy;
  assign done_o      = (state_q == S_HALT);
  assign err_o       = err_q;

endmodule

// File: tb/tb_core_seq.sv
// Directed bench for core_seq: an instruction-level model predicts every cycle's outputs.
module tb_core_seq;

  logic        clk = 1'b0, rst_n = 1'b0;
  logic        start = 1'b0, jen = 1'b0, is_ld = 1'b0, is_st = 1'b0, halt_op = 1'b0, mem_ack = 1'b0;
  logic [11:0] jump = '0;
  logic [11:0] pc;
  logic        ir_en, rf_wen_en, dm_req, dm_we, busy, done, err;
  logic [15:0] cycle_cnt, instr_cnt;

  logic        start2 = 1'b0, jen2 = 1'b0;
  logic [3:0]  jump2 = '0;
  logic [3:0]  pc2;
  logic        ir_en2, rf_wen_en2, dm_req2, dm_we2, busy2, done2, err2;
  logic [15:0] cycle_cnt2, instr_cnt2;

  always #5 clk = ~clk;

  core_seq dut (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start), .jen_i(jen), .jump_i(jump),
    .is_ld_i(is_ld), .is_st_i(is_st), .halt_op_i(halt_op), .mem_ack_i(mem_ack),
    .pc_o(pc), .ir_en_o(ir_en), .rf_wen_en_o(rf_wen_en), .dm_req_o(dm_req), .dm_we_o(dm_we),
    .busy_o(busy), .done_o(done), .err_o(err), .cycle_cnt_o(cycle_cnt), .instr_cnt_o(instr_cnt)
  );

  core_seq #(.PC_W(4), .DONE_PC(7), .MEM_TO(2)) dut2 (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start2), .jen_i(jen2), .jump_i(jump2),
    .is_ld_i(1'b0), .is_st_i(1'b0), .halt_op_i(1'b0), .mem_ack_i(1'b0),
    .pc_o(pc2), .ir_en_o(ir_en2), .rf_wen_en_o(rf_wen_en2), .dm_req_o(dm_req2), .dm_we_o(dm_we2),
    .busy_o(busy2), .done_o(done2), .err_o(err2), .cycle_cnt_o(cycle_cnt2), .instr_cnt_o(instr_cnt2)
  );

  int n_cmp = 0, n_bad = 0;
  bit chk = 1'b0;

  // model state: architectural view plus the strobes expected this cycle
  logic [11:0] e_pc = '0;
  logic [15:0] e_cyc = '0, e_ins = '0;
  bit e_done = 0, e_err = 0, e_ir = 0, e_rf = 0, e_req = 0, e_we = 0, e_busy = 0;

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk) begin
      cmp("pc",        32'(pc),        32'(e_pc));
      cmp("ir_en",     32'(ir_en),     32'(e_ir));
      cmp("rf_wen_en", 32'(rf_wen_en), 32'(e_rf));
      cmp("dm_req",    32'(dm_req),    32'(e_req));
      cmp("dm_we",     32'(dm_we),     32'(e_we));
      cmp("busy",      32'(busy),      32'(e_busy));
      cmp("done",      32'(done),      32'(e_done));
      cmp("err",       32'(err),       32'(e_err));
      cmp("cycle_cnt", 32'(cycle_cnt), 32'(e_cyc));
      cmp("instr_cnt", 32'(instr_cnt), 32'(e_ins));
    end
  end

  task automatic step(input bit ir, input bit rf, input bit req, input bit we, input bit bsy);
    e_ir = ir; e_rf = rf; e_req = req; e_we = we; e_busy = bsy;
    @(posedge clk); #1;
    if (bsy && e_cyc != 16'hFFFF) e_cyc++;
  endtask

  task automatic idle(input int n);
    repeat (n) step(0, 0, 0, 0, 0);
  endtask

  task automatic do_start();
    start = 1'b1;
    step(0, 0, 0, 0, 0);
    start = 1'b0;
    e_pc = '0; e_cyc = '0; e_ins = '0; e_done = 0; e_err = 0;
  endtask

  // one instruction; ack_n = MEM cycle carrying the ack (0 = never), noise = stray start/ack
  task automatic instr(input bit ld, input bit st, input bit hlt, input bit jn,
                       input logic [11:0] tgt, input int ack_n, input bit noise);
    bit halting;
    start = noise; mem_ack = noise;
    step(1, 0, 0, 0, 1);
    jen = jn; jump = tgt; is_ld = ld; is_st = st; halt_op = hlt;
    halting = hlt || (e_pc == 12'd58);
    step(0, 0, 0, 0, 1);
    jen = 0; jump = '0; is_ld = 0; is_st = 0; halt_op = 0; start = 0; mem_ack = 0;
    if (halting) begin
      e_done = 1;
      return;
    end
    if (ld || st) begin
      for (int k = 1; k <= 16; k++) begin
        mem_ack = (k == ack_n);
        step(0, 0, 1, st, 1);
        mem_ack = 0;
        if (k == ack_n) break;
        if (k == 16) begin
          e_done = 1; e_err = 1;
          return;
        end
      end
    end
    step(0, !st, 0, 0, 1);
    if (e_ins != 16'hFFFF) e_ins++;
    e_pc = jn ? tgt : e_pc + 12'd1;
  endtask

  initial begin
    #12;
    cmp("reset_pc",     32'(pc),        32'd0);
    cmp("reset_busy",   32'(busy),      32'd0);
    cmp("reset_done",   32'(done),      32'd0);
    cmp("reset_err",    32'(err),       32'd0);
    cmp("reset_dm_req", 32'(dm_req),    32'd0);
    cmp("reset_cycles", 32'(cycle_cnt), 32'd0);
    cmp("reset_instrs", 32'(instr_cnt), 32'd0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    chk = 1'b1;

    idle(2);
    do_start();
    repeat (3) instr(0, 0, 0, 0, '0, 0, 0);
    cmp("straight_pc",     32'(pc),        32'd3);
    cmp("straight_instrs", 32'(instr_cnt), 32'd3);
    cmp("straight_cycles", 32'(cycle_cnt), 32'd9);

    instr(0, 0, 0, 0, '0, 0, 1);
    instr(0, 0, 0, 0, '0, 0, 0);
    instr(0, 0, 0, 1, 12'h020, 0, 0);
    cmp("jump_pc",     32'(pc),        32'h020);
    cmp("jump_instrs", 32'(instr_cnt), 32'd6);

    instr(1, 0, 0, 0, '0, 4, 0);
    instr(0, 1, 0, 0, '0, 2, 0);
    instr(1, 1, 0, 0, '0, 1, 1);
    cmp("mem_cycles", 32'(cycle_cnt), 32'd34);
    cmp("mem_pc",     32'(pc),        32'h023);

    instr(1, 0, 0, 0, '0, 0, 0);
    cmp("timeout_err",    32'(err),       32'd1);
    cmp("timeout_done",   32'(done),      32'd1);
    cmp("timeout_cycles", 32'(cycle_cnt), 32'd52);
    idle(2);

    do_start();
    cmp("restart_pc",  32'(pc),  32'd0);
    cmp("restart_err", 32'(err), 32'd0);
    instr(1, 0, 0, 0, '0, 16, 0);
    cmp("ack_on_timeout_err", 32'(err), 32'd0);
    cmp("ack_on_timeout_pc",  32'(pc),  32'd1);

    instr(0, 0, 0, 1, 12'd57, 0, 0);
    instr(0, 0, 0, 0, '0, 0, 0);
    instr(0, 0, 0, 0, '0, 0, 0);
    cmp("donepc_done",   32'(done),      32'd1);
    cmp("donepc_busy",   32'(busy),      32'd0);
    cmp("donepc_instrs", 32'(instr_cnt), 32'd3);
    idle(2);

    do_start();
    cmp("halt_restart_done", 32'(done), 32'd0);
    instr(0, 0, 1, 0, '0, 0, 0);
    cmp("halt_op_done", 32'(done), 32'd1);
    idle(1);

    do_start();
    instr(0, 0, 0, 1, 12'h010, 0, 0);
    chk = 1'b0;
    @(posedge clk); #1;
    is_ld = 1'b1;
    @(posedge clk); #1;
    is_ld = 1'b0;
    cmp("pre_reset_dm_req", 32'(dm_req), 32'd1);
    cmp("pre_reset_pc",     32'(pc),     32'h010);
    rst_n = 1'b0;
    #1;
    cmp("async_reset_dm_req", 32'(dm_req),    32'd0);
    cmp("async_reset_pc",     32'(pc),        32'd0);
    cmp("async_reset_busy",   32'(busy),      32'd0);
    cmp("async_reset_cycles", 32'(cycle_cnt), 32'd0);
    @(negedge clk) rst_n = 1'b1;

    @(posedge clk); #1;
    start2 = 1'b1;
    @(posedge clk); #1;
    start2 = 1'b0;
    @(posedge clk); #1;
    jen2 = 1'b1; jump2 = 4'd15;
    @(posedge clk); #1;
    jen2 = 1'b0; jump2 = '0;
    @(posedge clk); #1;
    cmp("wrap_pre_pc", 32'(pc2), 32'd15);
    repeat (3) @(posedge clk);
    #1;
    cmp("wrap_pc",     32'(pc2),        32'd0);
    cmp("wrap_instrs", 32'(instr_cnt2), 32'd2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
